// File: rtl/tiny_cpu_pkg.sv
// rtl/tiny_cpu_pkg.sv - shared state encoding and defaults for the tiny core run controller
package tiny_cpu_pkg;

   localparam int unsigned PC_W_DEF    = 4;
   localparam int unsigned INST_W_DEF  = 8;
   // The core needs this many core_en ticks to complete one instruction
   localparam int unsigned CORE_PHASES = 5;

   typedef enum logic [2:0] {
      RC_IDLE = 3'd0,
      RC_RUN  = 3'd1,
      RC_STEP = 3'd2,
      RC_HALT = 3'd3,
      RC_LOAD = 3'd4
   } rc_state_e;

endpackage

// File: rtl/tiny_run_prescaler.sv
// rtl/tiny_run_prescaler.sv - free-run speed divider producing the RUN core_en tick
module tiny_run_prescaler
   import tiny_cpu_pkg::*;
#(
   parameter int unsigned DIV_W = 24
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_val,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt;

   assign tick = (div_cnt == div_val);

   // Count up to div_val and wrap; restart from zero whenever a run begins
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (clear) begin
         div_cnt <= '0;
      end else if (enable) begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/tiny_cpu_run_ctrl.sv
// rtl/tiny_cpu_run_ctrl.sv - run/step/halt sequencer and program loader; TINY_RUN_CTRL_INST_LIMIT_EN adds an instruction-limit watchdog
module tiny_cpu_run_ctrl
   import tiny_cpu_pkg::*;
#(
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned INST_W = INST_W_DEF,
   parameter int unsigned DIV_W  = 24,
   parameter int unsigned ICNT_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              run_req,
   input  logic              step_req,
   input  logic              halt_req,
   input  logic [DIV_W-1:0]  div_val,
   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_addr,
   input  logic [PC_W-1:0]   core_pc,
   input  logic              core_inst_done,
`ifdef TINY_RUN_CTRL_INST_LIMIT_EN
   input  logic [ICNT_W-1:0] inst_limit,
`endif
   input  logic              load_valid,
   input  logic [PC_W-1:0]   load_addr,
   input  logic [INST_W-1:0] load_data,
   output logic              load_ready,
   output logic              mem_we,
   output logic [PC_W-1:0]   mem_addr,
   output logic [INST_W-1:0] mem_wdata,
   output logic              core_en,
   output logic              core_rst,
   output logic [2:0]        state_o,
   output logic [ICNT_W-1:0] icount,
   output logic              bp_hit
);

   rc_state_e         state;
   rc_state_e         next_state;
   logic              tick;
   logic              in_run;
   logic              run_entry;
   logic              retire;
   logic              bp_trip;
   logic              limit_hit;
   logic              halt_pend;
   logic              boundary;
   logic              load_entry;
   logic              ctrl_state;
   logic [ICNT_W-1:0] icount_inc;

   assign state_o    = state;
   assign mem_addr   = load_addr;
   assign mem_wdata  = load_data;
   assign in_run     = (state == RC_RUN);
   assign ctrl_state = (state == RC_IDLE) || (state == RC_HALT);
   assign run_entry  = (next_state == RC_RUN) && !in_run;
   assign load_entry = (next_state == RC_LOAD) && (state != RC_LOAD);
   assign retire     = core_en & core_inst_done;
   assign icount_inc = (&icount) ? icount : icount + ICNT_W'(1);
   // boundary marks the cycle right after a retire, when core_pc shows the next instruction
   assign bp_trip    = in_run && boundary && bp_en && (core_pc == bp_addr);

`ifdef TINY_RUN_CTRL_INST_LIMIT_EN
   assign limit_hit = (inst_limit != '0) && (icount_inc == inst_limit);
`else
   assign limit_hit = 1'b0;
`endif

   tiny_run_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (run_entry),
      .enable  (in_run),
      .div_val (div_val),
      .tick    (tick)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RC_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection; step beats run beats load when idle or halted
   always_comb begin
      next_state = state;
      case (state)
         RC_IDLE, RC_HALT: begin
            if (step_req)        next_state = RC_STEP;
            else if (run_req)    next_state = RC_RUN;
            else if (load_valid) next_state = RC_LOAD;
         end
         RC_RUN: begin
            if (bp_trip)                                             next_state = RC_HALT;
            else if (retire && (halt_pend || halt_req || limit_hit)) next_state = RC_HALT;
         end
         RC_STEP: begin
            if (retire) next_state = RC_HALT;
         end
         RC_LOAD: begin
            if (!load_valid) next_state = RC_IDLE;
         end
         default: next_state = RC_IDLE;
      endcase
   end

   // Core enable/reset and program-write handshake decoded from the current state
   always_comb begin
      core_en    = 1'b0;
      core_rst   = 1'b0;
      load_ready = 1'b0;
      mem_we     = 1'b0;
      case (state)
         RC_IDLE: begin
            core_rst   = 1'b1;
            load_ready = 1'b1;
            mem_we     = load_valid && !run_req && !step_req;
         end
         RC_HALT: begin
            load_ready = 1'b1;
            mem_we     = load_valid && !run_req && !step_req;
         end
         RC_RUN:  core_en = tick && !bp_trip;
         RC_STEP: core_en = 1'b1;
         RC_LOAD: begin
            core_rst   = 1'b1;
            load_ready = 1'b1;
            mem_we     = load_valid;
         end
         default: core_rst = 1'b1;
      endcase
   end

   // Retire bookkeeping: instruction count, boundary marker, breakpoint and pending halt
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         icount    <= '0;
         bp_hit    <= 1'b0;
         halt_pend <= 1'b0;
         boundary  <= 1'b0;
      end else begin
         boundary <= retire;
         if (load_entry) begin
            icount <= '0;
         end else if (retire) begin
            icount <= icount_inc;
         end
         if (bp_trip) begin
            bp_hit <= 1'b1;
         end else if (ctrl_state && (run_req || step_req)) begin
            bp_hit <= 1'b0;
         end
         halt_pend <= (in_run && (next_state == RC_RUN)) ? (halt_pend | halt_req) : 1'b0;
      end
   end

endmodule

// File: tb/tb_tiny_cpu_run_ctrl.sv
// tb/tb_tiny_cpu_run_ctrl.sv - self-checking bench for tiny_cpu_run_ctrl against a behavioural model
module tb_tiny_cpu_run_ctrl;
   import tiny_cpu_pkg::*;

   localparam int PC_W     = 4;
   localparam int INST_W   = 8;
   localparam int DIV_W    = 24;
   localparam int ICNT_W   = 16;
   localparam int ICNT_MAX = (1 << ICNT_W) - 1;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              run_req = 1'b0;
   logic              step_req = 1'b0;
   logic              halt_req = 1'b0;
   logic [DIV_W-1:0]  div_val = '0;
   logic              bp_en = 1'b0;
   logic [PC_W-1:0]   bp_addr = '0;
   logic [PC_W-1:0]   core_pc;
   logic              core_inst_done;
   logic              load_valid = 1'b0;
   logic [PC_W-1:0]   load_addr = '0;
   logic [INST_W-1:0] load_data = '0;
   logic              load_ready;
   logic              mem_we;
   logic [PC_W-1:0]   mem_addr;
   logic [INST_W-1:0] mem_wdata;
   logic              core_en;
   logic              core_rst;
   logic [2:0]        state_o;
   logic [ICNT_W-1:0] icount;
   logic              bp_hit;
`ifdef TINY_RUN_CTRL_INST_LIMIT_EN
   logic [ICNT_W-1:0] inst_limit = '0;
`endif

   tiny_cpu_run_ctrl #(
      .PC_W   (PC_W),
      .INST_W (INST_W),
      .DIV_W  (DIV_W),
      .ICNT_W (ICNT_W)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .run_req        (run_req),
      .step_req       (step_req),
      .halt_req       (halt_req),
      .div_val        (div_val),
      .bp_en          (bp_en),
      .bp_addr        (bp_addr),
      .core_pc        (core_pc),
      .core_inst_done (core_inst_done),
`ifdef TINY_RUN_CTRL_INST_LIMIT_EN
      .inst_limit     (inst_limit),
`endif
      .load_valid     (load_valid),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .load_ready     (load_ready),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .core_en        (core_en),
      .core_rst       (core_rst),
      .state_o        (state_o),
      .icount         (icount),
      .bp_hit         (bp_hit)
   );

   always #5 clock = ~clock;

   // Stand-in core: five enabled phases per instruction, PC advances on write-back
   int unsigned       phase;
   logic [PC_W-1:0]   pc;
   logic [INST_W-1:0] prog [16];

   assign core_pc        = pc;
   assign core_inst_done = (phase == CORE_PHASES - 1);

   always @(posedge clock) begin
      if (core_rst) begin
         phase <= 0;
         pc    <= '0;
      end else if (core_en) begin
         if (phase == CORE_PHASES - 1) begin
            phase <= 0;
            pc    <= pc + PC_W'(1);
         end else begin
            phase <= phase + 1;
         end
      end
      if (mem_we) prog[mem_addr] <= mem_wdata;
   end

   int checks = 0;
   int errors = 0;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode codes 0 idle, 1 run, 2 step, 3 halt, 4 load
   int m_state, m_age, m_icount;
   bit m_bp_hit, m_halt_pend, m_boundary;
   int we_total = 0, en_total = 0;
   bit last_ret;

   task automatic model_reset();
      m_state = 0; m_age = 0; m_icount = 0;
      m_bp_hit = 0; m_halt_pend = 0; m_boundary = 0;
   endtask

   // Called at posedge+1 with inputs set; compares mid-cycle, then advances the model over the edge
   task automatic tick_cycle();
      int n_state, n_age, n_icount, d;
      bit n_bp, n_hp, e_idle, e_bp, e_en, e_we, ret;
      #3;
      d      = int'(div_val);
      e_idle = (m_state == 0) || (m_state == 3);
      e_bp   = (m_state == 1) && m_boundary && bp_en && (core_pc == bp_addr);
      e_en   = (m_state == 2) || ((m_state == 1) && ((m_age % (d + 1)) == d) && !e_bp);
      e_we   = load_valid && ((m_state == 4) || (e_idle && !run_req && !step_req));
      expect_eq("state", state_o, m_state);
      expect_eq("core_en", core_en, e_en);
      expect_eq("core_rst", core_rst, (m_state == 0) || (m_state == 4));
      expect_eq("load_ready", load_ready, e_idle || (m_state == 4));
      expect_eq("mem_we", mem_we, e_we);
      expect_eq("icount", icount, m_icount);
      expect_eq("bp_hit", bp_hit, m_bp_hit);
      if (e_we) begin
         expect_eq("mem_addr", mem_addr, load_addr);
         expect_eq("mem_wdata", mem_wdata, load_data);
      end
      if (mem_we) we_total++;
      if (core_en) en_total++;
      last_ret = core_en && core_inst_done;

      ret      = e_en && core_inst_done;
      n_state  = m_state;
      n_age    = m_age;
      n_bp     = m_bp_hit;
      n_hp     = 0;
      n_icount = m_icount;
      if (ret) n_icount = (m_icount >= ICNT_MAX) ? ICNT_MAX : m_icount + 1;
      if (e_idle) begin
         if (step_req) begin
            n_state = 2; n_bp = 0;
         end else if (run_req) begin
            n_state = 1; n_bp = 0; n_age = 0;
         end else if (load_valid) begin
            n_state = 4; n_icount = 0;
         end
      end else if (m_state == 1) begin
         n_age = m_age + 1;
         if (e_bp) begin
            n_state = 3; n_bp = 1;
         end else if (ret && (m_halt_pend || halt_req)) begin
            n_state = 3;
         end
`ifdef TINY_RUN_CTRL_INST_LIMIT_EN
         else if (ret && (inst_limit != 0) && (n_icount == int'(inst_limit))) begin
            n_state = 3;
         end
`endif
         if (n_state == 1) n_hp = m_halt_pend || halt_req;
      end else if (m_state == 2) begin
         if (ret) n_state = 3;
      end else if (m_state == 4) begin
         if (!load_valid) n_state = 0;
      end

      @(posedge clock);
      #1;
      m_state = n_state; m_age = n_age; m_icount = n_icount;
      m_bp_hit = n_bp; m_halt_pend = n_hp; m_boundary = ret;
      run_req = 0; step_req = 0; halt_req = 0;
   endtask

   task automatic wait_state(input int s, input int budget, input string tag);
      int k = 0;
      while (m_state != s && k < budget) begin
         tick_cycle();
         k++;
      end
      expect_eq(tag, state_o, s);
   endtask

   logic [INST_W-1:0] words [7];

   task automatic load_program();
      int w0 = we_total;
      for (int i = 0; i < 7; i++) begin
         load_valid = 1'b1;
         load_addr  = PC_W'(i);
         load_data  = words[i];
         tick_cycle();
      end
      load_valid = 1'b0;
      tick_cycle();
      expect_eq("load_we_count", we_total - w0, 7);
      expect_eq("load_idle", state_o, 0);
      expect_eq("load_icount", icount, 0);
      for (int i = 0; i < 7; i++) expect_eq("load_image", prog[i], words[i]);
   endtask

   task automatic async_reset();
      load_valid = 1'b0;
      run_req = 0; step_req = 0; halt_req = 0;
      reset_n = 1'b0;
      #1;
      expect_eq("arst_state", state_o, 0);
      expect_eq("arst_core_en", core_en, 0);
      expect_eq("arst_core_rst", core_rst, 1);
      expect_eq("arst_mem_we", mem_we, 0);
      expect_eq("arst_icount", icount, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int en0, first, r;
      words = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h84, 8'h82, 8'hA0};
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      expect_eq("rst_state", state_o, 0);
      expect_eq("rst_core_en", core_en, 0);
      expect_eq("rst_core_rst", core_rst, 1);
      expect_eq("rst_load_ready", load_ready, 1);
      expect_eq("rst_mem_we", mem_we, 0);
      expect_eq("rst_icount", icount, 0);
      expect_eq("rst_bp_hit", bp_hit, 0);
      reset_n = 1'b1;

      load_program();

      // Full-speed run, then halt requested on the second phase of an instruction
      div_val = '0;
      run_req = 1'b1;
      tick_cycle();
      en0 = en_total;
      repeat (20) tick_cycle();
      expect_eq("div0_en_count", en_total - en0, 20);
      expect_eq("div0_icount", icount, 4);
      tick_cycle();
      halt_req = 1'b1;
      tick_cycle();
      wait_state(3, 20, "halt_mid_state");
      expect_eq("halt_mid_icount", icount, 5);

      // Single step from HALT
      en0 = en_total;
      step_req = 1'b1;
      tick_cycle();
      wait_state(3, 20, "step_state");
      expect_eq("step_en_count", en_total - en0, 5);
      expect_eq("step_icount", icount, 6);

      // Divided run: first retire on the 20th cycle after entry
      div_val = DIV_W'(3);
      run_req = 1'b1;
      tick_cycle();
      first = -1;
      for (int k = 0; k < 30; k++) begin
         tick_cycle();
         if (last_ret && first < 0) first = k;
      end
      expect_eq("div3_first_retire", first, 19);
      halt_req = 1'b1;
      tick_cycle();
      wait_state(3, 40, "div3_halt_state");
      expect_eq("div3_icount", icount, 8);

      // Breakpoint at address 6 from a freshly loaded program
      load_program();
      bp_en   = 1'b1;
      bp_addr = PC_W'(6);
      div_val = '0;
      run_req = 1'b1;
      tick_cycle();
      wait_state(3, 60, "bp_state");
      expect_eq("bp_flag", bp_hit, 1);
      expect_eq("bp_icount", icount, 6);
      expect_eq("bp_pc", core_pc, 6);
      repeat (3) tick_cycle();
      expect_eq("bp_pc_hold", core_pc, 6);
      expect_eq("bp_phase_hold", phase, 0);
      run_req = 1'b1;
      tick_cycle();
      expect_eq("bp_clear", bp_hit, 0);
      repeat (3) tick_cycle();
      expect_eq("bp_resume_state", state_o, 1);
      halt_req = 1'b1;
      tick_cycle();
      wait_state(3, 20, "bp_resume_halt");
      bp_en = 1'b0;

      // Asynchronous reset in the middle of a run
      run_req = 1'b1;
      tick_cycle();
      repeat (7) tick_cycle();
      async_reset();

      // Randomised traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if (m_state != 1 && $urandom_range(0, 15) == 0) div_val = DIV_W'($urandom_range(0, 3));
         if ($urandom_range(0, 40) == 0) begin
            bp_en   = 1'($urandom_range(0, 1));
            bp_addr = PC_W'($urandom_range(0, 15));
         end
         r = int'($urandom_range(0, 99));
         run_req  = (r < 3) || (r >= 98);
         step_req = (r >= 3 && r < 6) || (r >= 98);
         halt_req = (r >= 6 && r < 10);
         if (m_state == 4) load_valid = ($urandom_range(0, 9) < 8);
         else load_valid = ($urandom_range(0, 39) == 0);
         load_addr = PC_W'($urandom_range(0, 15));
         load_data = INST_W'($urandom_range(0, 255));
         if ($urandom_range(0, 499) == 0) async_reset();
         else tick_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
